icache_arbiter: RTL and testbench

ICACHE_ARBITER -- requirements
Module: icache_arbiter

---
 rtl/icache_arbiter_pkg.sv | 14 +
 rtl/icache_arbiter_if.sv | 35 +++
 rtl/icache_arb_starve_cnt.sv | 15 +
 rtl/icache_arbiter.sv | 70 +++++++
 tb/tb_icache_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_arbiter_pkg.sv
// icache_arbiter_pkg: shared widths, FSM/owner encodings and block helper for the I-cache arbiter
package icache_arbiter_pkg;
  localparam int ADDR_W = 40;
  localparam int CBLOCK_W = 128;
  localparam int IDX_W = 12;
  localparam int VPN_W = ADDR_W - IDX_W;
  localparam int OFF_W = 4;
  localparam int BLK_W = ADDR_W - OFF_W;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;
  typedef enum logic {OWN_FETCH, OWN_PF} owner_e;
  function automatic logic [BLK_W-1:0] block_of(input logic [ADDR_W-1:0] pc);
    return pc[ADDR_W-1:OFF_W];
  endfunction
endpackage

// File: rtl/icache_arbiter_if.sv
// icache_arbiter_if: fetch, prefetch and I-cache/TLB signals seen by the arbiter
interface icache_arbiter_if;
  import icache_arbiter_pkg::*;
  logic fetch_req_valid;
  logic [ADDR_W-1:0] fetch_req_pc;
  logic fetch_kill;
  logic fetch_gnt;
  logic fetch_resp_valid;
  logic pf_req_valid;
  logic [ADDR_W-1:0] pf_req_pc;
  logic pf_gnt;
  logic pf_resp_valid;
  logic [CBLOCK_W-1:0] resp_data;
  logic resp_xcpt;
  logic icache_req_valid;
  logic [IDX_W-1:0] icache_req_idx;
  logic [VPN_W-1:0] tlb_req_vpn;
  logic icache_req_kill;
  logic icache_resp_valid;
  logic [CBLOCK_W-1:0] icache_resp_data;
  logic tlb_resp_miss;
  logic tlb_resp_xcpt;
  modport master (
    output fetch_req_valid, fetch_req_pc, fetch_kill, pf_req_valid, pf_req_pc,
           icache_resp_valid, icache_resp_data, tlb_resp_miss, tlb_resp_xcpt,
    input  fetch_gnt, fetch_resp_valid, pf_gnt, pf_resp_valid, resp_data, resp_xcpt,
           icache_req_valid, icache_req_idx, tlb_req_vpn, icache_req_kill
  );
  modport slave (
    input  fetch_req_valid, fetch_req_pc, fetch_kill, pf_req_valid, pf_req_pc,
           icache_resp_valid, icache_resp_data, tlb_resp_miss, tlb_resp_xcpt,
    output fetch_gnt, fetch_resp_valid, pf_gnt, pf_resp_valid, resp_data, resp_xcpt,
           icache_req_valid, icache_req_idx, tlb_req_vpn, icache_req_kill
  );
endinterface

// File: rtl/icache_arb_starve_cnt.sv
// icache_arb_starve_cnt: counts fetch grants won while the prefetcher waits, saturating at STARVE_MAX
module icache_arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [2:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt < 3'(STARVE_MAX)) cnt <= cnt + 3'd1;
endmodule

// File: rtl/icache_arbiter.sv
// icache_arbiter: single-outstanding arbiter between fetch and next-line prefetch into the I-cache/TLB
module icache_arbiter
  import icache_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  icache_arbiter_if.slave bus
);
  state_e state, state_n;
  owner_e owner, win;
  logic [BLK_W-1:0] blk;
  logic drain_cnt;
  logic [2:0] starve;
  logic fetch_ok, grant, kill_req, deliver;
  logic [ADDR_W-1:0] win_pc;
  assign fetch_ok = bus.fetch_req_valid && !bus.fetch_kill;
  assign win = (bus.pf_req_valid && (starve == 3'(STARVE_MAX) || !fetch_ok)) ? OWN_PF : OWN_FETCH;
  assign win_pc = win == OWN_PF ? bus.pf_req_pc : bus.fetch_req_pc;
  // grant is combinational, so it is gated by rst to keep outputs quiet during reset
  assign grant = rst && state == IDLE && (fetch_ok || bus.pf_req_valid);
  // a demand fetch to another block makes an in-flight prefetch useless
  assign kill_req = state == BUSY && (bus.fetch_kill ||
                    (owner == OWN_PF && bus.fetch_req_valid && block_of(bus.fetch_req_pc) != blk));
  assign deliver = state == BUSY && !kill_req &&
                   (bus.tlb_resp_xcpt || (!bus.tlb_resp_miss && bus.icache_resp_valid));
  icache_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(grant && win == OWN_FETCH && bus.pf_req_valid),
    .clr((grant && win == OWN_PF) || !bus.pf_req_valid),
    .cnt(starve)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_FETCH;
      blk <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state <= state_n;
      drain_cnt <= state == DRAIN && state_n == DRAIN;
      if (grant) begin
        owner <= win;
        blk <= block_of(win_pc);
      end
    end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = grant ? BUSY : IDLE;
    else if (state == BUSY)
      state_n = kill_req ? (bus.icache_resp_valid ? IDLE : DRAIN)
              : (bus.tlb_resp_xcpt || bus.tlb_resp_miss || bus.icache_resp_valid) ? IDLE : BUSY;
    else state_n = (bus.icache_resp_valid || drain_cnt) ? IDLE : DRAIN;
  end
  always_comb begin
    bus.fetch_gnt = grant && win == OWN_FETCH;
    bus.pf_gnt = grant && win == OWN_PF;
    bus.icache_req_valid = grant;
    bus.icache_req_idx = grant ? win_pc[IDX_W-1:0] : '0;
    bus.tlb_req_vpn = grant ? win_pc[ADDR_W-1:IDX_W] : '0;
    bus.fetch_resp_valid = deliver && owner == OWN_FETCH;
    bus.pf_resp_valid = deliver && owner == OWN_PF;
    bus.resp_xcpt = deliver && bus.tlb_resp_xcpt;
    bus.resp_data = (deliver && !bus.tlb_resp_xcpt) ? bus.icache_resp_data : '0;
    bus.icache_req_kill = kill_req || state == DRAIN ||
                          (state == BUSY && (bus.tlb_resp_xcpt || bus.tlb_resp_miss));
  end
endmodule

// File: tb/tb_icache_arbiter.sv
// tb_icache_arbiter: directed scenarios plus a randomized run against a behavioural arbiter model
module tb_icache_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  icache_arbiter_if bus();
  icache_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.fetch_req_valid = 0; bus.fetch_req_pc = '0; bus.fetch_kill = 0;
    bus.pf_req_valid = 0; bus.pf_req_pc = '0;
    bus.icache_resp_valid = 0; bus.icache_resp_data = '0;
    bus.tlb_resp_miss = 0; bus.tlb_resp_xcpt = 0;
  endtask
  function automatic logic [203:0] all_outs;
    return {bus.fetch_gnt, bus.pf_gnt, bus.fetch_resp_valid, bus.pf_resp_valid, bus.resp_xcpt,
            bus.icache_req_valid, bus.icache_req_kill, bus.resp_data, bus.icache_req_idx, bus.tlb_req_vpn};
  endfunction
  task automatic test_reset;
    idle_inputs();
    bus.fetch_req_valid = 1; bus.fetch_req_pc = 40'h1000; bus.pf_req_valid = 1;
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
    tick();
    idle_inputs();
    rst = 1;
  endtask
  task automatic test_fetch_basic;
    tick();
    bus.fetch_req_valid = 1; bus.fetch_req_pc = 40'h1000;
    @(negedge clk);
    checks++;
    if ({bus.fetch_gnt, bus.pf_gnt, bus.icache_req_valid} !== 3'b101) begin failures++; $display("FAIL basic_gnt got=%b exp=101", {bus.fetch_gnt, bus.pf_gnt, bus.icache_req_valid}); end
    checks++;
    if ({bus.icache_req_idx, bus.tlb_req_vpn} !== {12'h000, 28'h1}) begin failures++; $display("FAIL basic_addr got=%h/%h exp=000/1", bus.icache_req_idx, bus.tlb_req_vpn); end
    tick();
    bus.fetch_req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.fetch_resp_valid !== 1'b0) begin failures++; $display("FAIL basic_early_resp cyc=%0d got=%b exp=0", i, bus.fetch_resp_valid); end
      tick();
    end
    bus.icache_resp_valid = 1; bus.icache_resp_data = {16{8'hA5}};
    @(negedge clk);
    checks++;
    if ({bus.fetch_resp_valid, bus.pf_resp_valid, bus.resp_xcpt} !== 3'b100) begin failures++; $display("FAIL basic_resp got=%b exp=100", {bus.fetch_resp_valid, bus.pf_resp_valid, bus.resp_xcpt}); end
    checks++;
    if (bus.resp_data !== {16{8'hA5}}) begin failures++; $display("FAIL basic_data got=%h exp=%h", bus.resp_data, {16{8'hA5}}); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.fetch_resp_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", bus.fetch_resp_valid); end
  endtask
  task automatic test_starve;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.icache_resp_valid = 0;
      bus.fetch_req_valid = 1; bus.fetch_req_pc = 40'h2000;
      bus.pf_req_valid = 1; bus.pf_req_pc = 40'h2008;
      @(negedge clk);
      checks++;
      if ({bus.fetch_gnt, bus.pf_gnt} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL starve_order grant=%0d got=%b exp=%b", i, {bus.fetch_gnt, bus.pf_gnt}, (i % 5 == 4) ? 2'b01 : 2'b10); end
      tick();
      bus.icache_resp_valid = 1; bus.icache_resp_data = 128'(i);
      @(negedge clk);
      checks++;
      if ({bus.fetch_resp_valid, bus.pf_resp_valid} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL starve_route grant=%0d got=%b", i, {bus.fetch_resp_valid, bus.pf_resp_valid}); end
    end
    tick();
    idle_inputs();
  endtask
  task automatic test_kill_drain;
    tick();
    bus.fetch_req_valid = 1; bus.fetch_req_pc = 40'h3000;
    @(negedge clk);
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin failures++; $display("FAIL kill_gnt got=%b exp=1", bus.fetch_gnt); end
    tick();
    bus.fetch_req_valid = 0; bus.fetch_kill = 1;
    @(negedge clk);
    checks++;
    if ({bus.icache_req_kill, bus.fetch_resp_valid} !== 2'b10) begin failures++; $display("FAIL kill_busy got=%b exp=10", {bus.icache_req_kill, bus.fetch_resp_valid}); end
    tick();
    bus.fetch_kill = 0; bus.icache_resp_valid = 1; bus.icache_resp_data = '1;
    @(negedge clk);
    checks++;
    if ({bus.icache_req_kill, bus.fetch_resp_valid, bus.pf_resp_valid} !== 3'b100) begin failures++; $display("FAIL kill_late_resp got=%b exp=100", {bus.icache_req_kill, bus.fetch_resp_valid, bus.pf_resp_valid}); end
    tick();
    bus.icache_resp_valid = 0; bus.fetch_req_valid = 1; bus.fetch_req_pc = 40'h3010;
    @(negedge clk);
    checks++;
    if ({bus.fetch_gnt, bus.icache_req_kill} !== 2'b10) begin failures++; $display("FAIL kill_back_idle got=%b exp=10", {bus.fetch_gnt, bus.icache_req_kill}); end
    tick();
    bus.fetch_kill = 1; bus.fetch_req_valid = 0;
    tick();
    bus.fetch_kill = 0; bus.fetch_req_valid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.fetch_gnt, bus.icache_req_kill} !== 2'b01) begin failures++; $display("FAIL drain_hold cyc=%0d got=%b exp=01", i, {bus.fetch_gnt, bus.icache_req_kill}); end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({bus.fetch_gnt, bus.icache_req_kill} !== 2'b10) begin failures++; $display("FAIL drain_timeout got=%b exp=10", {bus.fetch_gnt, bus.icache_req_kill}); end
    tick();
    bus.fetch_req_valid = 0; bus.icache_resp_valid = 1;
    tick();
    idle_inputs();
  endtask
  task automatic test_kill_with_resp;
    tick();
    bus.fetch_req_valid = 1; bus.fetch_req_pc = 40'h4000;
    tick();
    bus.fetch_req_valid = 0; bus.fetch_kill = 1; bus.icache_resp_valid = 1; bus.icache_resp_data = 128'h77;
    @(negedge clk);
    checks++;
    if ({bus.fetch_resp_valid, bus.pf_resp_valid, bus.icache_req_kill} !== 3'b001) begin failures++; $display("FAIL kill_resp_same got=%b exp=001", {bus.fetch_resp_valid, bus.pf_resp_valid, bus.icache_req_kill}); end
    tick();
    bus.fetch_kill = 0; bus.icache_resp_valid = 0; bus.fetch_req_valid = 1;
    @(negedge clk);
    checks++;
    if ({bus.fetch_gnt, bus.icache_req_kill} !== 2'b10) begin failures++; $display("FAIL kill_resp_idle got=%b exp=10", {bus.fetch_gnt, bus.icache_req_kill}); end
    tick();
    bus.fetch_req_valid = 0; bus.icache_resp_valid = 1;
    tick();
    idle_inputs();
  endtask
  task automatic test_pf_xcpt;
    tick();
    bus.pf_req_valid = 1; bus.pf_req_pc = 40'h5040;
    @(negedge clk);
    checks++;
    if ({bus.fetch_gnt, bus.pf_gnt, bus.icache_req_idx, bus.tlb_req_vpn} !== {2'b01, 12'h040, 28'h5}) begin failures++; $display("FAIL pf_gnt got=%b %h %h exp=01 040 5", {bus.fetch_gnt, bus.pf_gnt}, bus.icache_req_idx, bus.tlb_req_vpn); end
    tick();
    bus.pf_req_valid = 0; bus.tlb_resp_xcpt = 1;
    @(negedge clk);
    checks++;
    if ({bus.pf_resp_valid, bus.fetch_resp_valid, bus.resp_xcpt, bus.icache_req_kill} !== 4'b1011) begin failures++; $display("FAIL pf_xcpt got=%b exp=1011", {bus.pf_resp_valid, bus.fetch_resp_valid, bus.resp_xcpt, bus.icache_req_kill}); end
    tick();
    bus.tlb_resp_xcpt = 0; bus.pf_req_valid = 1;
    @(negedge clk);
    checks++;
    if (bus.pf_gnt !== 1'b1) begin failures++; $display("FAIL pf_xcpt_idle got=%b exp=1", bus.pf_gnt); end
    tick();
    bus.tlb_resp_miss = 1;
    @(negedge clk);
    checks++;
    if ({bus.pf_resp_valid, bus.icache_req_kill} !== 2'b01) begin failures++; $display("FAIL pf_miss got=%b exp=01", {bus.pf_resp_valid, bus.icache_req_kill}); end
    tick();
    bus.tlb_resp_miss = 0;
    @(negedge clk);
    checks++;
    if (bus.pf_gnt !== 1'b1) begin failures++; $display("FAIL pf_miss_regrant got=%b exp=1", bus.pf_gnt); end
    tick();
    bus.pf_req_valid = 0; bus.icache_resp_valid = 1;
    tick();
    idle_inputs();
  endtask
  task automatic test_fetch_kill_idle;
    tick();
    bus.fetch_req_valid = 1; bus.fetch_kill = 1; bus.fetch_req_pc = 40'h8000;
    bus.pf_req_valid = 1; bus.pf_req_pc = 40'h8010;
    @(negedge clk);
    checks++;
    if ({bus.fetch_gnt, bus.pf_gnt} !== 2'b01) begin failures++; $display("FAIL fetch_kill_idle got=%b exp=01", {bus.fetch_gnt, bus.pf_gnt}); end
    tick();
    idle_inputs();
    bus.icache_resp_valid = 1;
    @(negedge clk);
    checks++;
    if ({bus.fetch_resp_valid, bus.pf_resp_valid} !== 2'b01) begin failures++; $display("FAIL fetch_kill_idle_resp got=%b exp=01", {bus.fetch_resp_valid, bus.pf_resp_valid}); end
    tick();
    idle_inputs();
  endtask
  task automatic test_reset_busy;
    tick();
    bus.fetch_req_valid = 1; bus.fetch_req_pc = 40'h6000;
    tick();
    rst = 0; bus.icache_resp_valid = 1; bus.tlb_resp_xcpt = 1;
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL reset_busy_outs got=%h exp=0", all_outs()); end
    tick();
    rst = 1; bus.icache_resp_valid = 0; bus.tlb_resp_xcpt = 0;
    @(negedge clk);
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin failures++; $display("FAIL reset_release_gnt got=%b exp=1", bus.fetch_gnt); end
    tick();
    bus.fetch_req_valid = 0; bus.icache_resp_valid = 1;
    tick();
    idle_inputs();
  endtask
  task automatic test_random;
    int mstate, mowner, mstarve, mdrain;
    logic [35:0] mblk;
    logic e_fg, e_pg, e_fr, e_pr, e_x, e_k;
    logic [11:0] e_idx;
    logic [27:0] e_vpn;
    logic [127:0] e_data;
    logic [39:0] gpc;
    logic killed;
    tick();
    rst = 0;
    tick();
    rst = 1;
    mstate = 0; mowner = 0; mstarve = 0; mdrain = 0; mblk = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      bus.fetch_req_valid = $urandom_range(0, 9) < 7;
      bus.fetch_kill = $urandom_range(0, 9) == 0;
      bus.fetch_req_pc = ($urandom_range(0, 3) == 0) ? {8'($urandom), 32'($urandom)} : 40'($urandom_range(0, 63));
      bus.pf_req_valid = $urandom_range(0, 1) == 1;
      bus.pf_req_pc = ($urandom_range(0, 3) == 0) ? {8'($urandom), 32'($urandom)} : 40'($urandom_range(0, 63));
      bus.icache_resp_valid = $urandom_range(0, 19) < 7;
      bus.icache_resp_data = {$urandom, $urandom, $urandom, $urandom};
      bus.tlb_resp_miss = $urandom_range(0, 11) == 0;
      bus.tlb_resp_xcpt = $urandom_range(0, 11) == 0;
      {e_fg, e_pg, e_fr, e_pr, e_x, e_k} = '0;
      e_idx = '0; e_vpn = '0; e_data = '0;
      if (mstate == 0) begin
        if (bus.pf_req_valid && (mstarve == 4 || !(bus.fetch_req_valid && !bus.fetch_kill))) e_pg = 1;
        else if (bus.fetch_req_valid && !bus.fetch_kill) e_fg = 1;
        gpc = e_pg ? bus.pf_req_pc : bus.fetch_req_pc;
        if (e_fg || e_pg) begin e_idx = gpc[11:0]; e_vpn = gpc[39:12]; end
      end else if (mstate == 1) begin
        killed = bus.fetch_kill || (mowner == 1 && bus.fetch_req_valid && bus.fetch_req_pc[39:4] != mblk);
        if (killed) e_k = 1;
        else if (bus.tlb_resp_xcpt) begin e_k = 1; e_x = 1; e_fr = mowner == 0; e_pr = mowner == 1; end
        else if (bus.tlb_resp_miss) e_k = 1;
        else if (bus.icache_resp_valid) begin e_fr = mowner == 0; e_pr = mowner == 1; e_data = bus.icache_resp_data; end
      end else e_k = 1;
      @(negedge clk);
      checks++;
      if ({bus.fetch_gnt, bus.pf_gnt, bus.icache_req_valid} !== {e_fg, e_pg, e_fg | e_pg}) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, {bus.fetch_gnt, bus.pf_gnt, bus.icache_req_valid}, {e_fg, e_pg, e_fg | e_pg}); end
      checks++;
      if ({bus.icache_req_idx, bus.tlb_req_vpn} !== {e_idx, e_vpn}) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h/%h exp=%h/%h", c, bus.icache_req_idx, bus.tlb_req_vpn, e_idx, e_vpn); end
      checks++;
      if ({bus.fetch_resp_valid, bus.pf_resp_valid, bus.resp_xcpt, bus.icache_req_kill} !== {e_fr, e_pr, e_x, e_k}) begin failures++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", c, {bus.fetch_resp_valid, bus.pf_resp_valid, bus.resp_xcpt, bus.icache_req_kill}, {e_fr, e_pr, e_x, e_k}); end
      checks++;
      if (bus.resp_data !== e_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, bus.resp_data, e_data); end
      if (mstate == 0) begin
        if (e_fg || e_pg) begin mstate = 1; mowner = e_pg ? 1 : 0; mblk = gpc[39:4]; end
      end else if (mstate == 1) begin
        if (killed) begin mstate = bus.icache_resp_valid ? 0 : 2; mdrain = 0; end
        else if (bus.tlb_resp_xcpt || bus.tlb_resp_miss || bus.icache_resp_valid) mstate = 0;
      end else begin
        if (bus.icache_resp_valid || mdrain == 1) mstate = 0;
        else mdrain++;
      end
      if (e_fg && bus.pf_req_valid) mstarve = (mstarve < 4) ? mstarve + 1 : 4;
      else if (e_pg || !bus.pf_req_valid) mstarve = 0;
    end
    tick();
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_fetch_basic();
    test_starve();
    test_kill_drain();
    test_kill_with_resp();
    test_pf_xcpt();
    test_fetch_kill_idle();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
